// File: rtl/mem_wb_stage_if.sv
`default_nettype none
// ============================================================================
//  mem_wb_stage_if : data-memory request/acknowledge bus for the MEM stage
//  Revision 1.0
// ============================================================================
interface mem_wb_stage_if #(
  parameter int DW = 32
);
  logic [DW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_rd;
  logic          mem_wr;
  logic [DW-1:0] mem_rdata;
  logic          mem_ack;

  modport master (
    output mem_addr, mem_wdata, mem_rd, mem_wr,
    input  mem_rdata, mem_ack
  );

  modport slave (
    input  mem_addr, mem_wdata, mem_rd, mem_wr,
    output mem_rdata, mem_ack
  );
endinterface
`default_nettype wire

// File: rtl/mem_wb_stage.sv
`default_nettype none
// ============================================================================
//  mem_wb_stage : memory-access stage + MEM/WB register; stalls until mem_ack.
//  Optional MEM_TIMEOUT_EN: aborts a request after TIMEOUT WAIT cycles.
//  Revision 1.0
// ============================================================================
module mem_wb_stage #(
  parameter int DW      = 32,
  parameter int TIMEOUT = 16
) (
  input  wire             clk,
  input  wire             reset_n,
  input  wire [DW-1:0]    dbus_in,
  input  wire [DW-1:0]    dselect_in,
  input  wire [DW-1:0]    databus_in,
  input  wire             sw_mem,
  input  wire             lw_mem,
  mem_wb_stage_if.master  mem_bus,
  output logic            stall_out,
  output logic [DW-1:0]   wb_data,
  output logic [DW-1:0]   wb_dselect,
  output logic            mem_err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t        state_q,      state_d;
  logic [DW-1:0] mem_addr_q,   mem_addr_d;
  logic [DW-1:0] mem_wdata_q,  mem_wdata_d;
  logic          mem_rd_q,     mem_rd_d;
  logic          mem_wr_q,     mem_wr_d;
  logic [DW-1:0] wb_data_q,    wb_data_d;
  logic [DW-1:0] wb_dselect_q, wb_dselect_d;
  logic [DW-1:0] dsel_cap_q,   dsel_cap_d;
  logic [DW-1:0] rdata_cap_q,  rdata_cap_d;
  logic          is_load_q,    is_load_d;

`ifdef MEM_TIMEOUT_EN
  localparam int             CW        = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0]  TIMEOUT_C = CW'(TIMEOUT);
  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] cnt_inc;
  logic          mem_err_q, mem_err_d;
  assign cnt_inc = cnt_q + CW'(1);
`endif

  always_comb begin
    state_d      = state_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    mem_rd_d     = mem_rd_q;
    mem_wr_d     = mem_wr_q;
    wb_data_d    = wb_data_q;
    wb_dselect_d = wb_dselect_q;
    dsel_cap_d   = dsel_cap_q;
    rdata_cap_d  = rdata_cap_q;
    is_load_d    = is_load_q;
    stall_out    = 1'b0;
`ifdef MEM_TIMEOUT_EN
    cnt_d        = cnt_q;
    mem_err_d    = mem_err_q;
`endif
    case (state_q)
      IDLE: begin
        if (sw_mem || lw_mem) begin
          stall_out    = 1'b1;
          mem_addr_d   = dbus_in;
          mem_wdata_d  = databus_in;
          mem_wr_d     = sw_mem;
          mem_rd_d     = lw_mem & ~sw_mem;
          is_load_d    = lw_mem & ~sw_mem;
          dsel_cap_d   = dselect_in;
          wb_dselect_d = '0;
          state_d      = WAIT;
`ifdef MEM_TIMEOUT_EN
          cnt_d        = '0;
`endif
        end else begin
          wb_data_d    = dbus_in;
          wb_dselect_d = dselect_in;
        end
      end
      WAIT: begin
        stall_out    = 1'b1;
        wb_dselect_d = '0;
        // An ack arriving on the terminal-count cycle still completes normally.
        if (mem_bus.mem_ack) begin
          mem_rd_d = 1'b0;
          mem_wr_d = 1'b0;
          if (is_load_q) rdata_cap_d = mem_bus.mem_rdata;
          state_d  = DONE;
        end
`ifdef MEM_TIMEOUT_EN
        else if (cnt_inc == TIMEOUT_C) begin
          mem_rd_d   = 1'b0;
          mem_wr_d   = 1'b0;
          mem_err_d  = 1'b1;
          dsel_cap_d = '0;
          state_d    = DONE;
        end else begin
          cnt_d = cnt_inc;
        end
`endif
      end
      DONE: begin
        // Inputs here are still the held memory instruction, so they are not reissued.
        if (is_load_q) begin
          wb_data_d    = rdata_cap_q;
          wb_dselect_d = dsel_cap_q;
        end else begin
          wb_data_d    = dbus_in;
          wb_dselect_d = '0;
        end
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      mem_rd_q     <= 1'b0;
      mem_wr_q     <= 1'b0;
      wb_data_q    <= '0;
      wb_dselect_q <= '0;
      dsel_cap_q   <= '0;
      rdata_cap_q  <= '0;
      is_load_q    <= 1'b0;
`ifdef MEM_TIMEOUT_EN
      cnt_q        <= '0;
      mem_err_q    <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      mem_rd_q     <= mem_rd_d;
      mem_wr_q     <= mem_wr_d;
      wb_data_q    <= wb_data_d;
      wb_dselect_q <= wb_dselect_d;
      dsel_cap_q   <= dsel_cap_d;
      rdata_cap_q  <= rdata_cap_d;
      is_load_q    <= is_load_d;
`ifdef MEM_TIMEOUT_EN
      cnt_q        <= cnt_d;
      mem_err_q    <= mem_err_d;
`endif
    end
  end

  assign mem_bus.mem_addr  = mem_addr_q;
  assign mem_bus.mem_wdata = mem_wdata_q;
  assign mem_bus.mem_rd    = mem_rd_q;
  assign mem_bus.mem_wr    = mem_wr_q;
  assign wb_data           = wb_data_q;
  assign wb_dselect        = wb_dselect_q;
`ifdef MEM_TIMEOUT_EN
  assign mem_err           = mem_err_q;
`else
  assign mem_err           = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_mem_wb_stage.sv
`default_nettype none
// ============================================================================
//  tb_mem_wb_stage : table-driven + scoreboard bench for mem_wb_stage
//  Revision 1.0
// ============================================================================
module tb_mem_wb_stage;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          reset_n;
  logic [DW-1:0] dbus_in, dselect_in, databus_in;
  logic          sw_mem, lw_mem;
  logic          stall_out, mem_err;
  logic [DW-1:0] wb_data, wb_dselect;

  always #5 clk = ~clk;

  mem_wb_stage_if #(.DW(DW)) bus ();

  mem_wb_stage #(.DW(DW), .TIMEOUT(16)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .dbus_in    (dbus_in),
    .dselect_in (dselect_in),
    .databus_in (databus_in),
    .sw_mem     (sw_mem),
    .lw_mem     (lw_mem),
    .mem_bus    (bus.master),
    .stall_out  (stall_out),
    .wb_data    (wb_data),
    .wb_dselect (wb_dselect),
    .mem_err    (mem_err)
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [DW-1:0] data;
    logic [DW-1:0] dsel;
  } wb_exp_t;
  wb_exp_t sb[$];

  typedef struct {
    logic [DW-1:0] dbus;
    logic [DW-1:0] dsel;
    logic          ack;
    logic [DW-1:0] exp_data;
    logic [DW-1:0] exp_dsel;
  } alu_vec_t;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_ops();
    sw_mem = 1'b0; lw_mem = 1'b0;
    dbus_in = '0; dselect_in = '0; databus_in = '0;
  endtask

  task automatic pop_check(input string name);
    wb_exp_t e;
    if (sb.size() == 0) begin
      checks++; errors++;
      $display("FAIL %s: got empty scoreboard expected one entry", name);
    end else begin
      e = sb.pop_front();
      chk({name, "_wb_data"}, wb_data, e.data);
      chk({name, "_wb_dselect"}, wb_dselect, e.dsel);
    end
  endtask

  task automatic do_mem(input string name, input logic sw, input logic lw,
                        input logic [DW-1:0] addr, input logic [DW-1:0] wdata,
                        input logic [DW-1:0] dsel, input int wait_cyc,
                        input logic [DW-1:0] rdata);
    logic    is_ld;
    int      stall_cnt;
    int      req_cnt;
    wb_exp_t e;
    is_ld = lw && !sw;
    stall_cnt = 0;
    req_cnt = 0;
    sw_mem = sw; lw_mem = lw; dbus_in = addr; databus_in = wdata; dselect_in = dsel;
    #1;
    if (stall_out) stall_cnt++;
    e.data = is_ld ? rdata : addr;
    e.dsel = is_ld ? dsel : '0;
    sb.push_back(e);
    step();
    chk({name, "_mem_addr"}, bus.mem_addr, addr);
    chk({name, "_mem_wdata"}, bus.mem_wdata, wdata);
    chk({name, "_mem_rd"}, bus.mem_rd, is_ld);
    chk({name, "_mem_wr"}, bus.mem_wr, sw);
    for (int i = 0; i < wait_cyc; i++) begin
      bus.mem_ack   = (i == wait_cyc - 1);
      bus.mem_rdata = bus.mem_ack ? rdata : (32'hBAD0_0000 + i);
      #1;
      if (stall_out) stall_cnt++;
      if (bus.mem_rd || bus.mem_wr) req_cnt++;
      chk({name, "_bubble"}, wb_dselect, '0);
      step();
    end
    bus.mem_ack = 1'b0;
    chk({name, "_done_stall"}, stall_out, 1'b0);
    chk({name, "_done_req"}, {bus.mem_rd, bus.mem_wr}, 2'b00);
    chk({name, "_stall_cycles"}, stall_cnt, wait_cyc + 1);
    chk({name, "_req_cycles"}, req_cnt, wait_cyc);
    step();
    pop_check(name);
    clear_ops();
  endtask

  alu_vec_t alu_tbl[4];

  initial begin
    alu_tbl[0] = '{32'h0000_0055, 32'h0000_0008, 1'b0, 32'h0000_0055, 32'h0000_0008};
    alu_tbl[1] = '{32'hFFFF_FFFF, 32'h8000_0000, 1'b0, 32'hFFFF_FFFF, 32'h8000_0000};
    alu_tbl[2] = '{32'h0000_0000, 32'h0000_0000, 1'b0, 32'h0000_0000, 32'h0000_0000};
    alu_tbl[3] = '{32'h0000_1234, 32'h0000_0001, 1'b1, 32'h0000_1234, 32'h0000_0001};

    reset_n = 1'b0;
    clear_ops();
    bus.mem_ack = 1'b0;
    bus.mem_rdata = '0;
    step();
    step();
    chk("rst_mem_addr", bus.mem_addr, '0);
    chk("rst_mem_wdata", bus.mem_wdata, '0);
    chk("rst_req", {bus.mem_rd, bus.mem_wr}, 2'b00);
    chk("rst_wb_data", wb_data, '0);
    chk("rst_wb_dselect", wb_dselect, '0);
    chk("rst_stall", stall_out, 1'b0);
    chk("rst_mem_err", mem_err, 1'b0);
    reset_n = 1'b1;

    // Non-memory ops: one-cycle writeback, never stall; stray ack is ignored.
    foreach (alu_tbl[i]) begin
      wb_exp_t e;
      dbus_in = alu_tbl[i].dbus;
      dselect_in = alu_tbl[i].dsel;
      bus.mem_ack = alu_tbl[i].ack;
      #1;
      chk("alu_no_stall", stall_out, 1'b0);
      e.data = alu_tbl[i].exp_data;
      e.dsel = alu_tbl[i].exp_dsel;
      sb.push_back(e);
      step();
      bus.mem_ack = 1'b0;
      pop_check("alu");
      chk("alu_no_req", {bus.mem_rd, bus.mem_wr}, 2'b00);
    end
    clear_ops();

    do_mem("lw", 1'b0, 1'b1, 32'h40, 32'h0, 32'h4, 1, 32'hDEAD_BEEF);
    do_mem("sw", 1'b1, 1'b0, 32'h80, 32'h1234, 32'h2, 5, 32'h0);
    do_mem("both", 1'b1, 1'b1, 32'hC0, 32'h5A5A, 32'h10, 2, 32'h1111_2222);
    do_mem("lw_slow", 1'b0, 1'b1, 32'h44, 32'h0, 32'h100, 3, 32'hCAFE_F00D);

    // Reset while waiting on an ack.
    lw_mem = 1'b1; dbus_in = 32'h48; dselect_in = 32'h2;
    step();
    chk("rstw_rd_before", bus.mem_rd, 1'b1);
    reset_n = 1'b0;
    clear_ops();
    step();
    reset_n = 1'b1;
    chk("rstw_req", {bus.mem_rd, bus.mem_wr}, 2'b00);
    chk("rstw_stall", stall_out, 1'b0);
    chk("rstw_wb_data", wb_data, '0);
    chk("rstw_wb_dselect", wb_dselect, '0);
    bus.mem_ack = 1'b1;
    bus.mem_rdata = 32'h7777_7777;
    step();
    bus.mem_ack = 1'b0;
    chk("rstw_late_ack", wb_dselect, '0);

`ifdef MEM_TIMEOUT_EN
    begin
      int rd_cnt;
      int guard;
      rd_cnt = 0;
      guard = 0;
      lw_mem = 1'b1; dbus_in = 32'h50; dselect_in = 32'h8;
      step();
      while (stall_out && guard < 40) begin
        if (bus.mem_rd) rd_cnt++;
        chk("to_bubble", wb_dselect, '0);
        step();
        guard++;
      end
      chk("to_bound", guard < 40, 1'b1);
      chk("to_rd_cycles", rd_cnt, 16);
      chk("to_rd_low", bus.mem_rd, 1'b0);
      chk("to_mem_err", mem_err, 1'b1);
      step();
      clear_ops();
      chk("to_wb_dselect", wb_dselect, '0);
      step();
      chk("to_err_sticky", mem_err, 1'b1);
    end
`else
    chk("mem_err_tied", mem_err, 1'b0);
`endif

    chk("sb_empty", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/mem_wb_stage.md
Name: mem_wb_stage

Overview:
- Memory-access stage plus MEM/WB pipeline register; consumes the EX/MEM outputs (ALU result, one-hot destination select, store data, store/load flags).
- Issues load/store requests to a data memory with a req/ack handshake.
- Stalls upstream pipeline stages until the memory acknowledges.
- Registers writeback data and destination select for the WB stage, inserting a bubble while stalled.

Parameters:
- DW, 32, data/address width.
- TIMEOUT, 16, max WAIT cycles before abort (used only with MEM_TIMEOUT_EN).

Ports:
- clk  input  1  rising-edge clock
- reset_n  input  1  synchronous, active-low reset
- dbus_in  input  DW  ALU result from EX/MEM; memory address for LW/SW
- dselect_in  input  DW  one-hot destination register select; all-zero = no writeback
- databus_in  input  DW  store data
- sw_mem  input  1  store instruction in MEM
- lw_mem  input  1  load instruction in MEM
- mem_addr  output  DW  memory address (registered)
- mem_wdata  output  DW  memory write data (registered)
- mem_rd  output  1  read request (registered)
- mem_wr  output  1  write request (registered)
- mem_rdata  input  DW  read data, valid with mem_ack
- mem_ack  input  1  one-cycle request completion
- stall_out  output  1  hold PC/IF/ID/EX/MEM registers (combinational)
- wb_data  output  DW  writeback data (registered)
- wb_dselect  output  DW  writeback destination select (registered)
- mem_err  output  1  timeout abort flag (MEM_TIMEOUT_EN only; else tied 0)

Behaviour:
- Reset (reset_n=0 at posedge): state=IDLE; mem_addr, mem_wdata, wb_data, wb_dselect = 0; mem_rd, mem_wr, mem_err = 0. Reset mid-WAIT drops the request immediately with no writeback.
- States: IDLE, WAIT, DONE.
- IDLE, no op (sw_mem=lw_mem=0): stall_out=0; each posedge wb_data<=dbus_in, wb_dselect<=dselect_in.
- IDLE, op present: stall_out=1; posedge latches mem_addr<=dbus_in, mem_wdata<=databus_in, mem_wr<=sw_mem, mem_rd<=lw_mem & ~sw_mem (SW wins if both set); captures dselect_in internally; wb_dselect<=0 (bubble); ->WAIT.
- WAIT: stall_out=1; wb_dselect<=0 each cycle. mem_ack=1: drop mem_rd/mem_wr; latch mem_rdata internally if load; ->DONE.
- DONE: stall_out=0 so EX/MEM advances. Posedge: wb_data<=captured rdata (LW) or dbus_in (SW); wb_dselect<=captured dselect (LW) or 0 (SW); ->IDLE. Ops presented in DONE are ignored; they are the same held instruction.
- mem_ack outside WAIT is ignored.
- Minimum load latency: op in IDLE at cycle 0, mem_rd high cycle 1, ack in cycle 1, DONE cycle 2, wb_data valid cycle 3. stall_out is high in cycles 0–1.
- Non-memory instruction: wb latency 1 cycle, no stall.

Optional Feature:
- MEM_TIMEOUT_EN defined:
  - Counter cleared on entering WAIT and incremented each WAIT cycle.
  - If it reaches TIMEOUT with no ack: drop mem_rd/mem_wr, set mem_err=1 (sticky until reset), ->DONE with wb_dselect<=0 (aborted load writes nothing).
  - Ack on the same cycle as the count reaching TIMEOUT takes priority; mem_err is not set.
- Not defined: WAIT waits indefinitely; mem_err tied 0; no counter logic.

Test Plan:
- ALU op dbus_in=0x0000_0055, dselect_in=0x0000_0008 -> next cycle wb_data=0x55, wb_dselect=0x8, stall_out never high.
- LW addr 0x40, mem_ack one cycle after mem_rd with rdata=0xDEAD_BEEF, dselect 0x4 -> mem_addr=0x40, stall 2 cycles, wb_data=0xDEADBEEF, wb_dselect=0x4 at cycle 3; wb_dselect=0 during stall.
- SW addr 0x80 data 0x1234, ack delayed 5 cycles -> mem_wr held 5 cycles, mem_wdata=0x1234, stall 6 cycles, wb_dselect=0 throughout.
- reset_n low while in WAIT -> next cycle mem_rd=mem_wr=0, stall_out=0, wb outputs 0, state IDLE.
- lw_mem and sw_mem both 1 -> only mem_wr asserted, no writeback.
- MEM_TIMEOUT_EN, TIMEOUT=16, no ack -> mem_rd drops after 16 WAIT cycles, mem_err=1, wb_dselect=0, pipeline resumes.
